// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter sharing one 2-bit magnitude comparator.
// Optional macro CMP_ONEHOT_CHECK_EN adds a sticky one-hot integrity check on the comparator result.
module cmp_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] opa0,
  input  logic [1:0] opb0,
  input  logic [1:0] opa1,
  input  logic [1:0] opb1,
  output logic       done0,
  output logic       done1,
  output logic [2:0] res0,
  output logic [2:0] res1,
  output logic       cmp_a1,
  output logic       cmp_a0,
  output logic       cmp_b1,
  output logic       cmp_b0,
  input  logic       cmp_r,
  input  logic       cmp_g,
  input  logic       cmp_b,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_gnt;
  logic       r_prio;
  logic       r_wait0;
  logic       r_wait1;

  logic       w_elig0;
  logic       w_elig1;
  logic       w_grant1;
  logic       w_start;
  logic       w_capture;
  logic [1:0] w_opa;
  logic [1:0] w_opb;
  logic [2:0] w_res;

  // A requester that was just served must drop req once before it is eligible again.
  assign w_elig0   = req0 & ~r_wait0;
  assign w_elig1   = req1 & ~r_wait1;
  assign w_grant1  = w_elig1 & (~w_elig0 | r_prio);
  assign w_start   = (r_state != S_DRIVE) & (w_elig0 | w_elig1);
  assign w_capture = (r_state == S_DRIVE) & (r_cnt == 4'd0);
  assign w_opa     = w_grant1 ? opa1 : opa0;
  assign w_opb     = w_grant1 ? opb1 : opb0;
  assign w_res     = {cmp_r, cmp_g, cmp_b};
  assign busy      = (r_state != S_IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_gnt   <= 1'b0;
      r_prio  <= 1'b0;
      r_wait0 <= 1'b0;
      r_wait1 <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res0    <= 3'b000;
      res1    <= 3'b000;
      cmp_a1  <= 1'b0;
      cmp_a0  <= 1'b0;
      cmp_b1  <= 1'b0;
      cmp_b0  <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (!req0) r_wait0 <= 1'b0;
      if (!req1) r_wait1 <= 1'b0;

      if (w_start) begin
        // DONE may hand straight over to the next grant for back-to-back throughput.
        r_state          <= S_DRIVE;
        r_gnt            <= w_grant1;
        r_cnt            <= CNT_LOAD;
        {cmp_a1, cmp_a0} <= w_opa;
        {cmp_b1, cmp_b0} <= w_opb;
      end else if (w_capture) begin
        r_state <= S_DONE;
        r_prio  <= ~r_gnt;
        if (r_gnt) begin
          res1    <= w_res;
          done1   <= 1'b1;
          r_wait1 <= 1'b1;
        end else begin
          res0    <= w_res;
          done0   <= 1'b1;
          r_wait0 <= 1'b1;
        end
      end else if (r_state == S_DRIVE) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
        cmp_a1  <= 1'b0;
        cmp_a0  <= 1'b0;
        cmp_b1  <= 1'b0;
        cmp_b0  <= 1'b0;
      end
    end
  end

`ifdef CMP_ONEHOT_CHECK_EN
  logic r_err;
  logic w_onehot;

  assign w_onehot = (w_res == 3'b100) | (w_res == 3'b010) | (w_res == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture && !w_onehot) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
